// File: rtl/alu_issue.sv
// RV32I operand-issue stage: decodes ALU operation and operands, then presents
// them through a two-entry registered skid buffer with valid/ready on both sides.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_COPY1
    } alu_sel_e;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_sel_e    sel;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        op1: 32'h0, op2: 32'h0, sel: ALU_ADD, rd: 5'd0, illegal: 1'b0
    };

endpackage

module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output alu_sel_e    aluSel,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e state;
    entry_t head;
    entry_t tail;
    entry_t dec;
    logic   bad;
    logic   push;
    logic   pop;

    wire [6:0]  opcode = inst[6:0];
    wire [2:0]  funct3 = inst[14:12];
    wire [6:0]  funct7 = inst[31:25];
    wire [31:0] imm_i  = {{20{inst[31]}}, inst[31:20]};
    wire [31:0] imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    wire [31:0] imm_u  = {inst[31:12], 12'h000};

    function automatic alu_sel_e f3_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        dec = '{op1: rs1_data, op2: imm_i, sel: ALU_ADD, rd: inst[11:7], illegal: 1'b0};
        bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.op2 = rs2_data;
                dec.sel = f3_sel(funct3);
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec.sel = ALU_SUB;
                    else if (funct3 == 3'b101) dec.sel = ALU_SRA;
                    else                       bad = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.sel = f3_sel(funct3);
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec.sel = ALU_SRA;
                    else if (funct7 != F7_BASE) bad = 1'b1;
                end else if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.op1 = imm_u;
                dec.op2 = 32'h0;
                dec.sel = ALU_COPY1;
            end
            OPC_AUIPC: begin
                dec.op1 = pc;
                dec.op2 = imm_u;
            end
            OPC_LOAD, OPC_JALR: ;
            OPC_STORE: dec.op2 = imm_s;
            default:   bad = 1'b1;
        endcase
        // Illegal entries still flow, forced to produce aluOut = 0 downstream.
        if (bad) begin
            dec.op1     = 32'h0;
            dec.op2     = 32'h0;
            dec.sel     = ALU_COPY1;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: both slots are reset so the outputs show defined values out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            head  <= RESET_ENTRY;
            tail  <= RESET_ENTRY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= dec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= dec;
                    end else if (push) begin
                        tail  <= dec;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign op1     = head.op1;
    assign op2     = head.op2;
    assign aluSel  = head.sel;
    assign rd      = head.rd;
    assign illegal = head.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage that feeds the ALU from the instruction side. It accepts an RV32I instruction word together with its register-file read data and PC, and decodes the opcode, funct3 and funct7 fields into the ALU operation select. It also selects and immediate-expands the two 32-bit ALU operands. Results are presented through a two-entry skid buffer with valid/ready handshakes on both sides, so the ALU-facing outputs are fully registered and back-pressure does not cost throughput.

## Interface
Parameters:
- none. Data width is fixed at 32 bits and the operation select uses the shared ALUSel enumeration.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept an instruction this cycle
- inst  in  32  RV32I instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read data for rs1
- rs2_data  in  32  register-file read data for rs2
- out_valid  out  1  issue entry presented to ALU side
- out_ready  in  1  downstream accepts the entry this cycle
- op1  out  32  ALU operand 1
- op2  out  32  ALU operand 2
- aluSel  out  ALUSel enum  ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, COPY1
- rd  out  5  destination register, inst[11:7]
- illegal  out  1  instruction not decodable by this stage

## Operation
Immediates:
- I = sext(inst[31:20])
- S = sext({inst[31:25], inst[11:7]})
- U = {inst[31:12], 12'h0}

Decode by opcode inst[6:0]:
- 0110011 OP: op1=rs1_data, op2=rs2_data.
  - funct3 000 → ADD, or SUB if funct7=0100000
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
  - 101 → SRL, or SRA if funct7=0100000
  - 110 → OR; 111 → AND
  - funct7 other than 0000000 or 0100000 → illegal. 0100000 with funct3 other than 000 or 101 → illegal.
- 0010011 OP-IMM: op1=rs1_data, op2=I. Same funct3 map with no SUB.
  - funct3 101: inst[31:25]=0100000 selects SRA; 0000000 selects SRL; any other value → illegal.
  - funct3 001 requires inst[31:25]=0000000, otherwise illegal.
- 0110111 LUI: op1=U, op2=0, COPY1.
- 0010111 AUIPC: op1=pc, op2=U, ADD.
- 0000011 LOAD and 1100111 JALR: op1=rs1_data, op2=I, ADD.
- 0100011 STORE: op1=rs1_data, op2=S, ADD.
- Any other opcode → illegal.
- An illegal entry is still issued with illegal=1, op1=0, op2=0 and aluSel=COPY1, so the downstream sees aluOut=0.

Buffer: a state machine over a two-slot FIFO.
- States: EMPTY, ONE, TWO. Reset state is EMPTY.
- in_ready = (state != TWO).
- out_valid = (state != EMPTY).
- Outputs always show the head slot. The head is registered, with no combinational path from inst to the outputs.
- An input handshake (in_valid & in_ready) writes the decoded entry.
- An output handshake (out_valid & out_ready) pops the head.
- Transitions:
  - EMPTY + push → ONE
  - ONE + push only → TWO
  - ONE + pop only → EMPTY
  - ONE + push + pop → ONE; the new entry becomes head
  - TWO + pop → ONE; the second slot moves to head
  - TWO does not accept a push
- Order is strictly FIFO. No entry is dropped or duplicated.
- Once out_valid is asserted, the head outputs must stay stable until out_ready is sampled high.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 instruction per cycle while out_ready=1.
- Reset (async assert, synchronous release):
  - state=EMPTY
  - out_valid=0, in_ready=1
  - op1=0, op2=0, aluSel=ADD, rd=0, illegal=0
- Asserting rst mid-transfer discards both slots immediately.
- While stalled, out_ready=0 for 2+ cycles fills TWO. in_ready drops on the cycle after the second push.
- in_ready depends only on registered state, never on out_ready.

## Test plan
- ADD and SUB: inst=0x00208133, then 0x40208133, with rs1_data=7, rs2_data=5, out_ready=1 → aluSel=ADD then SUB, op1=7, op2=5, rd=2, one cycle apart, illegal=0.
- SRAI: inst=0x40335293 with rs1_data=0x80000000 → aluSel=SRA, op1=0x80000000, op2=0x403, rd=5.
- LUI then AUIPC: LUI inst=0x123450B7 → aluSel=COPY1, op1=0x12345000. AUIPC inst=0x12345097 with pc=0x100 → aluSel=ADD, op1=0x100, op2=0x12345000.
- Back-pressure: hold out_ready=0 and push 3 back-to-back instructions → two are accepted, in_ready=0 on the third attempt. Release out_ready → the outputs drain in order A, B, then C is accepted. Outputs are stable throughout the stall.
- Illegal decode:
  - inst=0x0000007F → illegal=1, aluSel=COPY1, op1=0.
  - inst=0x40209133 (funct7=0100000 with SLL) → illegal=1.
- Reset mid-operation: fill to TWO, then pulse rst low between clock edges → out_valid=0 and in_ready=1 immediately; the first instruction pushed after release issues normally.
